// File: rtl/fetch_decode_reg.sv
// IF/ID pipeline register: captures Fetch fields, holds on stall, inserts NOP bubbles on flush.
// Optional performance counters (StallCount, BubbleCount) enabled by defining IFID_PERF_EN.
module fetch_decode_reg #(
  parameter int unsigned FlushDepth = 1,
  parameter logic [5:0]  NopOpCode  = 6'h00,
  parameter logic [5:0]  NopFunct   = 6'h15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [5:0]  InOpCode,
  input  logic [5:0]  InFunction,
  input  logic [31:0] InPCPlusFour,
  input  logic [4:0]  InRs1,
  input  logic [4:0]  InRs2,
  input  logic [4:0]  InRd,
  input  logic [15:0] InImmediate,
  output logic [5:0]  OpCode,
  output logic [5:0]  Function,
  output logic [31:0] PCPlusFour,
  output logic [4:0]  Rs1,
  output logic [4:0]  Rs2,
  output logic [4:0]  Rd,
  output logic [15:0] Immediate,
  output logic        Valid
`ifdef IFID_PERF_EN
  ,
  output logic [31:0] StallCount,
  output logic [31:0] BubbleCount
`endif
);

  typedef enum logic [1:0] {StFill, StRun, StHold, StSquash} state_e;

  localparam logic [1:0] BCntInit = 2'(FlushDepth - 1);

  state_e      state_q, state_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [5:0]  op_q, op_d, fn_q, fn_d;
  logic [31:0] pc_q, pc_d;
  logic [4:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [15:0] imm_q, imm_d;
  logic        valid_q, valid_d;
  logic        do_load, do_bubble;

  // Decide the slot action and next state; holding is the default.
  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    do_load   = 1'b0;
    do_bubble = 1'b0;
    if (flush) begin
      do_bubble = 1'b1;
      bcnt_d    = BCntInit;
      state_d   = (BCntInit == 2'd0) ? StRun : StSquash;
    end else begin
      unique case (state_q)
        StFill, StHold: begin
          if (!stall) begin
            do_load = 1'b1;
            state_d = StRun;
          end
        end
        StRun: begin
          if (stall) begin
            state_d = StHold;
          end else begin
            do_load = 1'b1;
          end
        end
        StSquash: begin
          if (!stall) begin
            if (bcnt_q == 2'd0) begin
              do_load = 1'b1;
              state_d = StRun;
            end else begin
              do_bubble = 1'b1;
              bcnt_d    = bcnt_q - 2'd1;
              if (bcnt_q == 2'd1) state_d = StRun;
            end
          end
        end
        default: state_d = StFill;
      endcase
    end
  end

  always_comb begin
    op_d    = op_q;
    fn_d    = fn_q;
    pc_d    = pc_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    imm_d   = imm_q;
    valid_d = valid_q;
    if (do_bubble) begin
      // A bubble keeps the squashed instruction's PC+4 for debug traceability.
      op_d    = NopOpCode;
      fn_d    = NopFunct;
      pc_d    = InPCPlusFour;
      rs1_d   = '0;
      rs2_d   = '0;
      rd_d    = '0;
      imm_d   = '0;
      valid_d = 1'b0;
    end else if (do_load) begin
      op_d    = InOpCode;
      fn_d    = InFunction;
      pc_d    = InPCPlusFour;
      rs1_d   = InRs1;
      rs2_d   = InRs2;
      rd_d    = InRd;
      imm_d   = InImmediate;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFill;
      bcnt_q  <= 2'd0;
      op_q    <= NopOpCode;
      fn_q    <= NopFunct;
      pc_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      op_q    <= op_d;
      fn_q    <= fn_d;
      pc_q    <= pc_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      imm_q   <= imm_d;
      valid_q <= valid_d;
    end
  end

  assign OpCode     = op_q;
  assign Function   = fn_q;
  assign PCPlusFour = pc_q;
  assign Rs1        = rs1_q;
  assign Rs2        = rs2_q;
  assign Rd         = rd_q;
  assign Immediate  = imm_q;
  assign Valid      = valid_q;

`ifdef IFID_PERF_EN
  logic [31:0] stall_cnt_q, bubble_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (stall && !flush) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (do_bubble)       bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign StallCount  = stall_cnt_q;
  assign BubbleCount = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_decode_reg.sv
// Directed self-checking bench for fetch_decode_reg with FlushDepth=2.
// Counter checks are compiled in when IFID_PERF_EN is defined.
module tb_fetch_decode_reg;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [5:0]  InOpCode, InFunction;
  logic [31:0] InPCPlusFour;
  logic [4:0]  InRs1, InRs2, InRd;
  logic [15:0] InImmediate;
  logic [5:0]  OpCode, Function;
  logic [31:0] PCPlusFour;
  logic [4:0]  Rs1, Rs2, Rd;
  logic [15:0] Immediate;
  logic        Valid;
`ifdef IFID_PERF_EN
  logic [31:0] StallCount, BubbleCount;
  logic [31:0] sc0, bc0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  fetch_decode_reg #(
    .FlushDepth(2),
    .NopOpCode (6'h00),
    .NopFunct  (6'h15)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .InOpCode    (InOpCode),
    .InFunction  (InFunction),
    .InPCPlusFour(InPCPlusFour),
    .InRs1       (InRs1),
    .InRs2       (InRs2),
    .InRd        (InRd),
    .InImmediate (InImmediate),
    .OpCode      (OpCode),
    .Function    (Function),
    .PCPlusFour  (PCPlusFour),
    .Rs1         (Rs1),
    .Rs2         (Rs2),
    .Rd          (Rd),
    .Immediate   (Immediate),
    .Valid       (Valid)
`ifdef IFID_PERF_EN
    ,
    .StallCount  (StallCount),
    .BubbleCount (BubbleCount)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] pc);
    InOpCode     = op;
    InPCPlusFour = pc;
  endtask

  task automatic check_bubble(input string tag, input logic [31:0] pc);
    check_eq({tag, "_valid"}, 64'(Valid), 64'h0);
    check_eq({tag, "_op"}, 64'(OpCode), 64'h00);
    check_eq({tag, "_fn"}, 64'(Function), 64'h15);
    check_eq({tag, "_pc"}, 64'(PCPlusFour), 64'(pc));
    check_eq({tag, "_rs1"}, 64'(Rs1), 64'h0);
  endtask

  task automatic check_load(input string tag, input logic [5:0] op, input logic [31:0] pc);
    check_eq({tag, "_valid"}, 64'(Valid), 64'h1);
    check_eq({tag, "_op"}, 64'(OpCode), 64'(op));
    check_eq({tag, "_pc"}, 64'(PCPlusFour), 64'(pc));
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    InFunction = 6'h20; InRs1 = 5'd3; InRs2 = 5'd4; InRd = 5'd5; InImmediate = 16'hbeef;
    drive(6'h23, 32'h04);
    #2;
    // Reset values before any clock edge.
    check_bubble("rst", 32'h0);
    check_eq("rst_imm", 64'(Immediate), 64'h0);
`ifdef IFID_PERF_EN
    check_eq("rst_scnt", 64'(StallCount), 64'h0);
    check_eq("rst_bcnt", 64'(BubbleCount), 64'h0);
`endif
    step();
    check_bubble("rst_edge", 32'h0);
    #3 reset = 1'b0;

    // FILL with stall keeps reset contents.
    stall = 1'b1;
    step();
    check_bubble("fill_stall", 32'h0);
    stall = 1'b0;

    step();
    check_load("first", 6'h23, 32'h04);
    check_eq("first_fn", 64'(Function), 64'h20);
    check_eq("first_rs2", 64'(Rs2), 64'h4);
    check_eq("first_rd", 64'(Rd), 64'h5);
    check_eq("first_imm", 64'(Immediate), 64'hbeef);

    drive(6'h08, 32'h08);
    step();
    check_load("run08", 6'h08, 32'h08);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(6'(6'h30 + i), 32'h100 + 32'(i));
      InRs1 = 5'(i + 9);
      step();
      check_load("hold", 6'h08, 32'h08);
      check_eq("hold_rs1", 64'(Rs1), 64'h3);
    end
    stall = 1'b0;
    drive(6'h2b, 32'h0c);
    step();
    check_load("release", 6'h2b, 32'h0c);
    check_eq("release_rs1", 64'(Rs1), 64'hb);

    // Flush pulse with depth 2: two bubbles then a load.
    flush = 1'b1;
    drive(6'h01, 32'h10);
    step();
    check_bubble("fl_b1", 32'h10);
    flush = 1'b0;
    drive(6'h01, 32'h14);
    step();
    check_bubble("fl_b2", 32'h14);
    drive(6'h02, 32'h18);
    step();
    check_load("fl_load", 6'h02, 32'h18);

    // Flush then stall: bubble and count frozen, one more bubble after release.
    flush = 1'b1;
    drive(6'h01, 32'h20);
    step();
    check_bubble("fs_b1", 32'h20);
    flush = 1'b0;
    stall = 1'b1;
    drive(6'h01, 32'h24);
    step();
    check_bubble("fs_hold1", 32'h20);
    step();
    check_bubble("fs_hold2", 32'h20);
    stall = 1'b0;
    drive(6'h01, 32'h28);
    step();
    check_bubble("fs_b2", 32'h28);
    drive(6'h03, 32'h2c);
    step();
    check_load("fs_load", 6'h03, 32'h2c);

    // Flush and stall on the same edge: flush wins.
`ifdef IFID_PERF_EN
    sc0 = StallCount;
    bc0 = BubbleCount;
`endif
    flush = 1'b1;
    stall = 1'b1;
    drive(6'h01, 32'h30);
    step();
    check_bubble("fsame", 32'h30);
`ifdef IFID_PERF_EN
    check_eq("fsame_scnt", 64'(StallCount), 64'(sc0));
    check_eq("fsame_bcnt", 64'(BubbleCount), 64'(bc0 + 32'd1));
`endif
    flush = 1'b0;
    stall = 1'b0;

    // Async reset mid-SQUASH, released before the next edge.
    #2 reset = 1'b1;
    #1;
    check_bubble("async_rst", 32'h0);
`ifdef IFID_PERF_EN
    check_eq("async_rst_bcnt", 64'(BubbleCount), 64'h0);
`endif
    #2 reset = 1'b0;
    drive(6'h23, 32'h40);
    step();
    check_load("post_rst", 6'h23, 32'h40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_decode_reg.md
# fetch_decode_reg

IF/ID pipeline register between the Fetch stage and the Decode stage. Captures the decoded instruction fields and PC+4 from Fetch each cycle, holds them on a pipeline stall, and replaces them with a configurable number of NOP bubbles when a control transfer squashes the wrong-path instruction. A small state machine tracks post-reset fill, normal flow, stall hold and squash.

## Interface

- FlushDepth, 1, bubbles inserted per flush (legal 1..3)
- NopOpCode, 6'h00, opcode driven for a bubble
- NopFunct, 6'h15, function field driven for a bubble (NOP encoding)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- stall  in  1  hold current contents (from hazard unit / Decode)
- flush  in  1  squash: taken jump/branch resolved in Decode
- InOpCode, InFunction  in  6 each  from Fetch
- InPCPlusFour  in  32  from Fetch
- InRs1, InRs2, InRd  in  5 each  from Fetch
- InImmediate  in  16  from Fetch
- OpCode, Function  out  6 each  to Decode
- PCPlusFour  out  32  to Decode
- Rs1, Rs2, Rd  out  5 each  to Decode
- Immediate  out  16  to Decode
- Valid  out  1  1 = registered slot holds a real instruction, 0 = bubble
- StallCount, BubbleCount  out  32 each  only with IFID_PERF_EN

## Operation

- States: FILL, RUN, HOLD, SQUASH; plus 2-bit bubble counter BCnt.
- Edge priority: reset > flush > stall > load.
- Load: all outputs take In* values, Valid=1.
- Bubble load: OpCode=NopOpCode, Function=NopFunct, PCPlusFour=InPCPlusFour of squashed instruction, Rs1/Rs2/Rd/Immediate=0, Valid=0.
- FILL: entered on reset. stall=1 -> stay FILL, outputs unchanged. stall=0 -> load, go RUN. flush -> bubble load, SQUASH path as below.
- RUN: stall=0 -> load, stay RUN. stall=1 -> hold all outputs, go HOLD.
- HOLD: outputs frozen while stall=1; stall=0 -> load, go RUN.
- flush (any state, regardless of stall): bubble load; BCnt=FlushDepth-1; BCnt=0 -> RUN, else SQUASH.
- SQUASH: stall=1 -> hold outputs and BCnt. stall=0 -> bubble load, BCnt-=1; when BCnt reaches 0 go RUN (next unstalled edge loads).
- flush inside SQUASH reloads BCnt=FlushDepth-1 (does not accumulate).

## Timing

- Latency: Fetch fields appear on outputs 1 cycle after the capturing edge.
- Reset (async assert): OpCode=NopOpCode, Function=NopFunct, PCPlusFour=0, Rs1/Rs2/Rd/Immediate=0, Valid=0, state FILL, BCnt=0, counters 0. Outputs change without waiting for clk.
- Reset deassert mid-squash or mid-stall: FILL behaviour restarts; no stale bubbles remain.
- flush and stall same edge: flush wins, bubble inserted.
- Outputs are pure register outputs; no combinational In* -> out path.
- FlushDepth=1: exactly one bubble, return to RUN on that edge.

## Configuration

- IFID_PERF_EN defined: StallCount increments on every edge with stall=1 and flush=0 (not in reset); BubbleCount increments on every bubble load. Both 32-bit, wrap at 2^32-1 -> 0, reset to 0.
- Undefined: counters and ports absent; remaining behaviour identical.

## Test plan

- Reset, then stall=0, InOpCode=6'h23, InPCPlusFour=32'h04 -> after 1 edge OpCode=6'h23, PCPlusFour=32'h04, Valid=1; during reset OpCode=6'h00, Function=6'h15, Valid=0.
- RUN with 0x08 loaded, stall=1 for 3 edges while In* changes -> outputs stay 0x08 fields; stall=0 -> next input loaded.
- FlushDepth=2, flush pulse 1 cycle with InPCPlusFour=32'h10 -> two consecutive edges give Valid=0, OpCode=0x00, Function=0x15; third edge loads input, Valid=1.
- FlushDepth=2, flush then stall=1 for 2 edges -> bubble held, BCnt frozen; after release one more bubble then load.
- flush=1 and stall=1 same edge -> bubble inserted, Valid=0; with IFID_PERF_EN StallCount unchanged, BubbleCount+1.
- Assert reset asynchronously mid-SQUASH (between edges) -> outputs return to reset values immediately; after release, first unstalled edge loads input (no residual bubbles).
